coin_scheduler: RTL and testbench

//  Sits between three coin-slot detectors and the vending_machine FSM. Arbitrates simultaneous coin

---
 rtl/coin_pkg.sv | 29 ++
 rtl/rr_arb3.sv | 33 +++
 rtl/coin_scheduler.sv | 119 +++++++++++
 tb/tb_coin_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared encodings for the coin scheduler: FSM states, coin slot indices and slot helpers.
package coin_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_GAP    = 3'd2,
      S_CHECK  = 3'd3,
      S_PAY_HI = 3'd4,
      S_PAY_LO = 3'd5
   } state_t;

   localparam int C_ONE  = 0;
   localparam int C_TWO  = 1;
   localparam int C_FIVE = 2;

   // Slot visited after idx in the one -> two -> five -> one rotation
   function automatic logic [1:0] next_slot(input logic [1:0] idx);
      return (idx == 2'(C_FIVE)) ? 2'(C_ONE) : idx + 2'd1;
   endfunction

   // Index of the set bit in a one-hot slot vector
   function automatic logic [1:0] slot_of(input logic [2:0] oh);
      if (oh[C_FIVE]) return 2'(C_FIVE);
      if (oh[C_TWO])  return 2'(C_TWO);
      return 2'(C_ONE);
   endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: grants the first requester at or after ptr,
// searching one -> two -> five -> one. Purely combinational.
module rr_arb3
   import coin_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt
);

   // Priority search starting at the slot named by ptr
   always_comb begin
      gnt = 3'b000;
      case (ptr)
         2'(C_TWO): begin
            if (req[C_TWO])       gnt = 3'b010;
            else if (req[C_FIVE]) gnt = 3'b100;
            else if (req[C_ONE])  gnt = 3'b001;
         end
         2'(C_FIVE): begin
            if (req[C_FIVE])      gnt = 3'b100;
            else if (req[C_ONE])  gnt = 3'b001;
            else if (req[C_TWO])  gnt = 3'b010;
         end
         default: begin
            if (req[C_ONE])       gnt = 3'b001;
            else if (req[C_TWO])  gnt = 3'b010;
            else if (req[C_FIVE]) gnt = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/coin_scheduler.sv
// Coin scheduler: arbitrates coin-slot requests, feeds one coin at a time to the
// vending machine, samples its dispense/change answer and pulses the change hopper.
// Every output is a flop fed from the current/next state, so no input reaches an
// output combinationally.
module coin_scheduler
   import coin_pkg::*;
#(
   parameter int GAP_CYC    = 1,
   parameter int PAY_LO_CYC = 2,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       coin_req,
   output logic [2:0]       coin_ack,
   output logic             one,
   output logic             two,
   output logic             five,
   input  logic             d,
   input  logic [2:0]       r,
   output logic             hopper,
   output logic             busy,
   output logic             vend_done,
   output logic [CNT_W-1:0] vend_count
);

   localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
   localparam int LO_W  = (PAY_LO_CYC < 2) ? 1 : $clog2(PAY_LO_CYC + 1);

   state_t            state;
   state_t            state_nx;
   logic [1:0]        ptr;
   logic [1:0]        grant;
   logic [2:0]        gnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [LO_W-1:0]   lo_cnt;
   logic [2:0]        pay_cnt;

   rr_arb3 u_arb (
      .req (coin_req),
      .ptr (ptr),
      .gnt (gnt)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; counters are compared at 1 so each wait phase lasts exactly its load value
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (gnt != 3'b000) state_nx = S_ISSUE;
         S_ISSUE:  state_nx = S_GAP;
         S_GAP:    if (gap_cnt == GAP_W'(1)) state_nx = S_CHECK;
         S_CHECK:  state_nx = (r != 3'd0) ? S_PAY_HI : S_IDLE;
         S_PAY_HI: state_nx = S_PAY_LO;
         S_PAY_LO: begin
            if (lo_cnt == LO_W'(1)) state_nx = (pay_cnt != 3'd0) ? S_PAY_HI : S_IDLE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   // Grant latch, round-robin pointer, phase counters and dispense counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant      <= 2'(C_ONE);
         ptr        <= 2'(C_ONE);
         gap_cnt    <= '0;
         lo_cnt     <= '0;
         pay_cnt    <= '0;
         vend_count <= '0;
      end else begin
         case (state)
            S_IDLE:   if (gnt != 3'b000) grant <= slot_of(gnt);
            S_ISSUE: begin
               ptr     <= next_slot(grant);
               gap_cnt <= GAP_W'(GAP_CYC);
            end
            S_GAP:    gap_cnt <= gap_cnt - GAP_W'(1);
            S_CHECK: begin
               pay_cnt <= r;
               if (d) vend_count <= vend_count + CNT_W'(1);
            end
            S_PAY_HI: begin
               pay_cnt <= pay_cnt - 3'd1;
               lo_cnt  <= LO_W'(PAY_LO_CYC);
            end
            S_PAY_LO: lo_cnt <= lo_cnt - LO_W'(1);
            default:  ;
         endcase
      end
   end

   // Registered outputs: the coin pulse and ack fire on the IDLE->ISSUE edge so they are high during ISSUE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coin_ack  <= 3'b000;
         one       <= 1'b0;
         two       <= 1'b0;
         five      <= 1'b0;
         hopper    <= 1'b0;
         busy      <= 1'b0;
         vend_done <= 1'b0;
      end else begin
         coin_ack  <= (state == S_IDLE) ? gnt : 3'b000;
         one       <= (state == S_IDLE) && gnt[C_ONE];
         two       <= (state == S_IDLE) && gnt[C_TWO];
         five      <= (state == S_IDLE) && gnt[C_FIVE];
         hopper    <= (state_nx == S_PAY_HI);
         busy      <= (state_nx != S_IDLE);
         vend_done <= (state == S_CHECK) && d;
      end
   end

endmodule

// File: tb/tb_coin_scheduler.sv
// Randomized scoreboard bench for coin_scheduler. A timeline model predicts, for each
// batch of coin requests, when every coin pulse, vend_done and hopper pulse must appear
// and which cycles are busy; a negedge monitor pops and compares those predictions.
module tb_coin_scheduler;

   localparam int GAP_CYC    = 1;
   localparam int PAY_LO_CYC = 2;
   localparam int CNT_W      = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [2:0]       coin_req = 3'b000;
   logic             d = 1'b0;
   logic [2:0]       r = 3'b000;
   logic [2:0]       coin_ack;
   logic             one, two, five, hopper, busy, vend_done;
   logic [CNT_W-1:0] vend_count;

   coin_scheduler #(
      .GAP_CYC    (GAP_CYC),
      .PAY_LO_CYC (PAY_LO_CYC),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .coin_req   (coin_req),
      .coin_ack   (coin_ack),
      .one        (one),
      .two        (two),
      .five       (five),
      .d          (d),
      .r          (r),
      .hopper     (hopper),
      .busy       (busy),
      .vend_done  (vend_done),
      .vend_count (vend_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int t; int coin; } coin_ev_t;
   typedef struct { int t; int cnt; }  vend_ev_t;
   typedef struct { bit disp; int chg; } resp_t;

   coin_ev_t coin_q[$];
   vend_ev_t vend_q[$];
   int       hop_q[$];
   resp_t    resp_in[$];
   resp_t    resp_drv[$];
   bit       busy_exp[int];

   int checks = 0;
   int fails  = 0;

   // model state: next slot to favour, dispense count, wrap seen
   int m_ptr = 0;
   int m_count = 0;
   bit m_wrapped = 1'b0;

   int         extra_t = -1;
   logic [2:0] extra_mask = 3'b000;
   int         ghost_on = -1;
   int         ghost_off = -1;
   logic [2:0] ghost_mask = 3'b000;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void add_resp(input bit disp, input int chg);
      resp_t x;
      x.disp = disp;
      x.chg  = chg;
      resp_in.push_back(x);
   endfunction

   // Timeline model: requests present at cycle t0 (plus an optional later extra request).
   // A coin granted while idle at cycle n pulses at n+1; its answer is seen GAP_CYC+1 cycles
   // later; vend_done and the first hopper pulse follow one cycle after that; hopper pulses
   // are PAY_LO_CYC+1 apart; the scheduler is idle again once the last low gap ends.
   function automatic int plan(input int t0, input logic [2:0] mask);
      logic [2:0] pend;
      bit         ex;
      int         now, t, g, base;
      resp_t      rs;
      coin_ev_t   ce;
      vend_ev_t   ve;
      pend = mask;
      ex   = (extra_mask != 3'b000);
      now  = t0;
      while (1) begin
         if (ex && extra_t <= now) begin
            pend = pend | extra_mask;
            ex = 1'b0;
         end
         if (pend == 3'b000) begin
            if (!ex) break;
            now = extra_t;
            continue;
         end
         g = -1;
         for (int k = 0; k < 3; k++)
            if (g < 0 && pend[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
         pend[g] = 1'b0;
         m_ptr = (g + 1) % 3;
         rs = resp_in.pop_front();
         resp_drv.push_back(rs);
         t = now + 1;
         ce.t = t;
         ce.coin = g;
         coin_q.push_back(ce);
         base = t + GAP_CYC + 2;
         if (rs.disp) begin
            m_count = (m_count + 1) % (1 << CNT_W);
            if (m_count == 0) m_wrapped = 1'b1;
            ve.t = base;
            ve.cnt = m_count;
            vend_q.push_back(ve);
         end
         for (int k = 0; k < rs.chg; k++) hop_q.push_back(base + k * (PAY_LO_CYC + 1));
         now = base + rs.chg * (PAY_LO_CYC + 1);
         for (int c = t; c < now; c++) busy_exp[c] = 1'b1;
      end
      resp_in.delete();
      return now;
   endfunction

   // Plays the coin slots and the vending machine cycle by cycle up to cycle endc
   task automatic drive_until(input int endc);
      resp_t rs;
      while (cyc < endc) begin
         @(posedge clk);
         #1;
         if (coin_ack != 3'b000) coin_req = coin_req & ~coin_ack;
         if ({five, two, one} != 3'b000) begin
            if (resp_drv.size() == 0) chk("resp_available", 0, 1);
            else begin
               rs = resp_drv.pop_front();
               d = rs.disp;
               r = 3'(rs.chg);
            end
         end
         if (cyc == extra_t)   coin_req = coin_req | extra_mask;
         if (cyc == ghost_on)  coin_req = coin_req | ghost_mask;
         if (cyc == ghost_off) coin_req = coin_req & ~ghost_mask;
      end
   endtask

   task automatic run_batch(input logic [2:0] mask);
      int endc;
      @(posedge clk);
      #1;
      coin_req = coin_req | mask;
      endc = plan(cyc, mask);
      drive_until(endc);
      extra_mask = 3'b000;
      extra_t    = -1;
      ghost_mask = 3'b000;
      ghost_on   = -1;
      ghost_off  = -1;
   endtask

   // Monitor: compares every presented output against the scoreboard queues
   always @(negedge clk) begin : monitor
      logic [2:0] p;
      coin_ev_t   ce;
      vend_ev_t   ve;
      int         ht;
      if (reset) begin
         p = {five, two, one};
         if (p != 3'b000 || coin_ack != 3'b000) begin
            chk("ack_equals_pulse", 32'(coin_ack), 32'(p));
            chk("pulse_onehot", 32'($onehot(p)), 1);
            if (coin_q.size() == 0) chk("coin_unexpected", 32'(p), 0);
            else begin
               ce = coin_q.pop_front();
               chk("coin_cycle", cyc, ce.t);
               chk("coin_slot", 32'(p), 32'(1 << ce.coin));
            end
         end
         if (vend_done) begin
            if (vend_q.size() == 0) chk("vend_unexpected", 1, 0);
            else begin
               ve = vend_q.pop_front();
               chk("vend_cycle", cyc, ve.t);
               chk("vend_count", 32'(vend_count), ve.cnt);
            end
         end
         if (hopper) begin
            if (hop_q.size() == 0) chk("hopper_unexpected", 1, 0);
            else begin
               ht = hop_q.pop_front();
               chk("hopper_cycle", cyc, ht);
            end
         end
         chk("busy", 32'(busy), 32'(busy_exp.exists(cyc)));
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int h1, endc;
      logic [2:0] m;

      // reset held low for two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hopper_low", 32'(hopper), 0);
      chk("rst_busy_low", 32'(busy), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_pulses", 32'({five, two, one}), 0);
      chk("idle_ack", 32'(coin_ack), 0);
      chk("idle_hopper", 32'(hopper), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_vend_done", 32'(vend_done), 0);
      chk("idle_vend_count", 32'(vend_count), 0);

      // all three requesters at once straight from reset: one, two, five
      repeat (3) add_resp(1'b0, 0);
      run_batch(3'b111);

      // single one-coin, no dispense, no change
      add_resp(1'b0, 0);
      run_batch(3'b001);

      // dispense with 3 change; a two request arrives mid-payout, a five request comes and goes
      add_resp(1'b1, 3);
      add_resp(1'b0, 0);
      extra_mask = 3'b010;
      extra_t    = cyc + 1 + 1 + GAP_CYC + 3;
      ghost_mask = 3'b100;
      ghost_on   = cyc + 1 + 1 + GAP_CYC + 4;
      ghost_off  = cyc + 1 + 1 + GAP_CYC + 6;
      run_batch(3'b001);

      // maximum change
      add_resp(1'b1, 7);
      run_batch(3'b100);

      // dispense until the counter wraps past 2^CNT_W-1
      while (!m_wrapped) begin
         repeat (3) add_resp(1'b1, 0);
         run_batch(3'b111);
      end
      chk("vend_count_wrapped", 32'(vend_count), m_count);

      // randomized batches with an optional late request
      for (int b = 0; b < 30; b++) begin
         m = 3'($urandom_range(1, 7));
         repeat (4) add_resp(1'($urandom_range(0, 1)), $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            extra_mask = 3'($urandom_range(1, 7));
            extra_t    = cyc + 1 + $urandom_range(2, 20);
         end
         run_batch(m);
      end

      // reset during the low gap with two hopper pulses still owed
      add_resp(1'b0, 4);
      @(posedge clk);
      #1;
      coin_req = 3'b001;
      endc = plan(cyc, 3'b001);
      h1 = hop_q[1];
      drive_until(h1 + 1);
      #2;
      reset = 1'b0;
      #1;
      chk("midpay_reset_hopper", 32'(hopper), 0);
      chk("midpay_reset_busy", 32'(busy), 0);
      chk("midpay_reset_count", 32'(vend_count), 0);
      while (hop_q.size() > 0 && hop_q[hop_q.size() - 1] > cyc) void'(hop_q.pop_back());
      for (int c = cyc; c <= endc; c++) if (busy_exp.exists(c)) busy_exp.delete(c);
      resp_drv.delete();
      coin_req = 3'b000;
      d = 1'b0;
      r = 3'b000;
      m_ptr = 0;
      m_count = 0;
      repeat (2) @(negedge clk);
      chk("reset_hold_hopper", 32'(hopper), 0);
      reset = 1'b1;
      repeat (8) @(negedge clk);

      // after reset the pointer favours one again and counting restarts
      repeat (3) add_resp(1'b1, 0);
      run_batch(3'b111);

      repeat (3) @(negedge clk);
      chk("coin_queue_drained", coin_q.size(), 0);
      chk("vend_queue_drained", vend_q.size(), 0);
      chk("hopper_queue_drained", hop_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
